// File: rtl/dds_pkg.sv
// rtl/dds_pkg.sv - shared DDS widths, phase state and configuration shadow types
package dds_pkg;

  // Default widths, shared with the sine / minus-sine ROM blocks
  localparam int DDS_ACC_WIDTH     = 32;
  localparam int DDS_ROM_ADDR_BITS = 12;

  typedef logic [DDS_ACC_WIDTH-1:0]     acc_word_t;
  typedef logic [DDS_ROM_ADDR_BITS-1:0] rom_addr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    SWEEP = 2'd2
  } dds_state_t;

  // One configuration word as captured on the cfg handshake
  typedef struct packed {
    logic      sweep_en;
    acc_word_t ftw;
    rom_addr_t pow;
    acc_word_t step;
    acc_word_t limit;
  } dds_cfg_t;

endpackage

// File: rtl/dds_ftw_ctrl.sv
// rtl/dds_ftw_ctrl.sv - configuration shadow, handshake, phase FSM and FTW sweep
import dds_pkg::*;

module dds_ftw_ctrl #(
  parameter int ACC_WIDTH     = DDS_ACC_WIDTH,
  parameter int ROM_ADDR_BITS = DDS_ROM_ADDR_BITS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ce,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [ACC_WIDTH-1:0]     cfg_ftw,
  input  logic [ROM_ADDR_BITS-1:0] cfg_pow,
  input  logic                     cfg_sweep_en,
  input  logic [ACC_WIDTH-1:0]     cfg_sweep_step,
  input  logic [ACC_WIDTH-1:0]     cfg_sweep_limit,
  output logic [ACC_WIDTH-1:0]     ftw,
  output logic [ROM_ADDR_BITS-1:0] pow,
  output dds_state_t               state,
  output logic                     sweep_done
);

  dds_cfg_t                 shadow_q;
  logic                     pending_q;
  dds_state_t               state_q, state_d;
  logic [ACC_WIDTH-1:0]     ftw_q, ftw_d;
  logic [ACC_WIDTH-1:0]     step_q, limit_q;
  logic [ROM_ADDR_BITS-1:0] pow_q;
  logic                     sweep_done_q, sweep_done_d;

  logic                     accept, apply, start_sweep, sweep_hit;
  logic [ACC_WIDTH-1:0]     sh_ftw, sh_step, sh_limit;
  logic [ROM_ADDR_BITS-1:0] sh_pow;
  logic [ACC_WIDTH:0]       sweep_sum;

  assign sh_ftw   = ACC_WIDTH'(shadow_q.ftw);
  assign sh_step  = ACC_WIDTH'(shadow_q.step);
  assign sh_limit = ACC_WIDTH'(shadow_q.limit);
  assign sh_pow   = ROM_ADDR_BITS'(shadow_q.pow);

  // Capture is independent of ce; the shadow only reaches the datapath on a ce cycle
  assign accept      = cfg_valid && cfg_ready;
  assign apply       = ce && pending_q;
  assign start_sweep = shadow_q.sweep_en && (sh_limit > sh_ftw);
  // One extra bit so a large step cannot wrap past the limit unnoticed
  assign sweep_sum   = {1'b0, ftw_q} + {1'b0, step_q};
  assign sweep_hit   = sweep_sum >= {1'b0, limit_q};

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state: a new configuration always wins over an in-progress sweep
  always_comb begin
    state_d = state_q;
    if (apply) begin
      state_d = start_sweep ? SWEEP : RUN;
    end else if (ce && (state_q == SWEEP) && sweep_hit) begin
      state_d = RUN;
    end
  end

  // Outputs: handshake ready, next FTW and the sweep-done pulse
  always_comb begin
    cfg_ready    = !pending_q;
    ftw_d        = ftw_q;
    sweep_done_d = 1'b0;
    if (apply) begin
      ftw_d        = sh_ftw;
      sweep_done_d = shadow_q.sweep_en && !start_sweep;
    end else if (ce && (state_q == SWEEP)) begin
      if (sweep_hit) begin
        ftw_d        = limit_q;
        sweep_done_d = 1'b1;
      end else begin
        ftw_d = sweep_sum[ACC_WIDTH-1:0];
      end
    end
  end

  // Shadow, pending flag and the live tuning registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_q     <= '0;
      pending_q    <= 1'b0;
      ftw_q        <= '0;
      pow_q        <= '0;
      step_q       <= '0;
      limit_q      <= '0;
      sweep_done_q <= 1'b0;
    end else begin
      if (accept) begin
        shadow_q  <= '{sweep_en: cfg_sweep_en,
                       ftw:      acc_word_t'(cfg_ftw),
                       pow:      rom_addr_t'(cfg_pow),
                       step:     acc_word_t'(cfg_sweep_step),
                       limit:    acc_word_t'(cfg_sweep_limit)};
        pending_q <= 1'b1;
      end else if (apply) begin
        pending_q <= 1'b0;
      end
      if (apply) begin
        pow_q   <= sh_pow;
        step_q  <= sh_step;
        limit_q <= sh_limit;
      end
      ftw_q        <= ftw_d;
      sweep_done_q <= sweep_done_d;
    end
  end

  assign ftw        = ftw_q;
  assign pow        = pow_q;
  assign state      = state_q;
  assign sweep_done = sweep_done_q;

endmodule

// File: rtl/dds_phase_accumulator.sv
// rtl/dds_phase_accumulator.sv - DDS phase accumulator driving the sine ROM address
import dds_pkg::*;

module dds_phase_accumulator #(
  parameter int ACC_WIDTH     = DDS_ACC_WIDTH,
  parameter int ROM_ADDR_BITS = DDS_ROM_ADDR_BITS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ce,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [ACC_WIDTH-1:0]     cfg_ftw,
  input  logic [ROM_ADDR_BITS-1:0] cfg_pow,
  input  logic                     cfg_sweep_en,
  input  logic [ACC_WIDTH-1:0]     cfg_sweep_step,
  input  logic [ACC_WIDTH-1:0]     cfg_sweep_limit,
  output logic [ROM_ADDR_BITS-1:0] addr,
  output logic                     addr_valid,
  output logic                     wrap,
  output logic                     sweep_done
);

  logic [ACC_WIDTH-1:0]     ftw;
  logic [ROM_ADDR_BITS-1:0] pow;
  dds_state_t               state;

  logic [ACC_WIDTH-1:0]     acc_q;
  logic [ACC_WIDTH:0]       acc_sum;
  logic                     advance;

  dds_ftw_ctrl #(
    .ACC_WIDTH     (ACC_WIDTH),
    .ROM_ADDR_BITS (ROM_ADDR_BITS)
  ) u_ftw_ctrl (
    .clk             (clk),
    .rst             (rst),
    .ce              (ce),
    .cfg_valid       (cfg_valid),
    .cfg_ready       (cfg_ready),
    .cfg_ftw         (cfg_ftw),
    .cfg_pow         (cfg_pow),
    .cfg_sweep_en    (cfg_sweep_en),
    .cfg_sweep_step  (cfg_sweep_step),
    .cfg_sweep_limit (cfg_sweep_limit),
    .ftw             (ftw),
    .pow             (pow),
    .state           (state),
    .sweep_done      (sweep_done)
  );

  // The apply cycle still advances with the old ftw/pow held by the controller
  assign advance    = ce && (state != IDLE);
  assign acc_sum    = {1'b0, acc_q} + {1'b0, ftw};
  assign addr_valid = (state != IDLE);

  // Accumulate phase and register the truncated, offset ROM address with its carry
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
      addr  <= '0;
      wrap  <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (advance) begin
        acc_q <= acc_sum[ACC_WIDTH-1:0];
        addr  <= acc_sum[ACC_WIDTH-1 -: ROM_ADDR_BITS] + pow;
        wrap  <= acc_sum[ACC_WIDTH];
      end
    end
  end

endmodule

// File: doc/dds_phase_accumulator.md
# dds_phase_accumulator

Phase-generation stage of the DDS core. It holds the frequency tuning word (FTW) and phase offset (POW), accumulates phase every clock-enabled cycle, and drives the truncated, offset phase as the address of the sine/minus-sine ROMs directly downstream. A valid/ready configuration port loads new settings phase-continuously. An optional linear frequency sweep ramps the FTW up to a limit.

## Interface
- ACC_WIDTH, 32, phase accumulator / FTW / sweep word width
- ROM_ADDR_BITS, 12, output address width (top bits of accumulator); must be ≤ ACC_WIDTH
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-low
- ce  in  1  clock enable; shared with the downstream ROMs
- cfg_valid  in  1  configuration word present
- cfg_ready  out  1  block can accept a configuration
- cfg_ftw  in  ACC_WIDTH  new tuning word (start FTW when sweeping)
- cfg_pow  in  ROM_ADDR_BITS  phase offset added to the address
- cfg_sweep_en  in  1  enable linear sweep
- cfg_sweep_step  in  ACC_WIDTH  FTW increment per ce cycle while sweeping
- cfg_sweep_limit  in  ACC_WIDTH  final FTW of sweep
- addr  out  ROM_ADDR_BITS  ROM address
- addr_valid  out  1  addr carries a live phase
- wrap  out  1  one-cycle pulse: accumulator carried out this update
- sweep_done  out  1  one-cycle pulse: sweep reached limit

## Operation
- Reset (rst=0, async): acc=0, ftw=0, pow=0, addr=0, addr_valid=0, wrap=0, sweep_done=0, cfg_ready=1, pending=0, state IDLE.
- Handshake: transfer when cfg_valid && cfg_ready, independent of ce. All cfg_* fields captured into a shadow register; pending=1; cfg_ready=0 from the next cycle. cfg_ready returns to 1 the cycle after the shadow is applied. A cfg_valid held while cfg_ready=0 is not accepted.
- Apply: first cycle with ce=1 and pending=1. ftw←shadow ftw, pow←shadow pow, pending←0. Next state is SWEEP if sweep_en && limit > ftw_shadow. Otherwise it is RUN. If sweep_en && limit ≤ ftw_shadow, the block goes to RUN and pulses sweep_done that cycle. The accumulator is not cleared (phase-continuous).
- States:
  - IDLE: acc frozen, addr_valid=0. Leaves only via apply.
  - RUN: each ce cycle acc←acc+ftw.
  - SWEEP: each ce cycle acc←acc+ftw and ftw←ftw+step. The sum is computed in ACC_WIDTH+1 bits, unsigned. If the sum ≥ limit, then ftw←limit, sweep_done pulses and the state goes to RUN.
- A new configuration in RUN or SWEEP is applied the same way; a sweep in progress is abandoned.
- Address: on each advancing ce cycle, addr←acc_next[ACC_WIDTH-1 -: ROM_ADDR_BITS] + pow, modulo 2^ROM_ADDR_BITS, where acc_next = acc + ftw. wrap=1 on a carry out of acc+ftw.
- addr_valid=1 in RUN/SWEEP, else 0.
- ce=0: acc, ftw, pow, addr, state hold; wrap and sweep_done are 0. Configuration capture still works.

## Timing
- Apply cycle uses the old ftw/pow. The new ftw/pow affect addr from the next ce cycle.
- addr is registered: it reflects acc_next one cycle after the ce edge. The ROM adds its own latency downstream.
- Single accept to cfg_ready high again: minimum 2 cycles (accept, apply), longer while ce=0.
- wrap and sweep_done are registered alongside addr, asserted for exactly one clk cycle.
- Reset mid-sweep or mid-handshake: everything returns to reset values immediately, and any pending shadow is discarded.

## Structure
- dds_pkg holds:
  - default ACC_WIDTH and ROM_ADDR_BITS constants, shared with the ROM blocks;
  - typedef enum {IDLE, RUN, SWEEP} for the state;
  - packed struct typedef for the configuration shadow.
- One sub-module, dds_ftw_ctrl, owns the shadow, the handshake, the FSM and the sweep arithmetic. It outputs ftw/pow/state to the accumulator datapath in the top.

## Test plan
Defaults ACC_WIDTH=32, ROM_ADDR_BITS=12.
- Reset, ce=1, no cfg → addr=0, addr_valid=0, cfg_ready=1 indefinitely. Assert rst mid-run → outputs cleared the same cycle.
- cfg_ftw=0x0010_0000, pow=0 → addr goes 1,2,3… one per cycle after apply. After 4096 advances it wraps to 0 with one wrap pulse.
- Same config with ce toggling 1,0,1,0 → addr advances only on ce=1 cycles. Accept cfg during ce=0 → applied on the next ce=1 cycle.
- RUN at ftw=0x0010_0000, then load pow=0x400 with the same ftw → addr jumps by +1024 beyond the normal +1 without an acc reset.
- Sweep: ftw=0x0010_0000, step=0x0010_0000, limit=0x0040_0000 → addr increments 1,2,3,4,4,4…; sweep_done pulses once as ftw reaches 0x0040_0000.
- Backpressure: cfg_valid held high for 5 cycles with ce=0 → exactly one capture. cfg_ready stays 0 until the apply cycle after ce rises.
